// File: rtl/emailbox_tx.sv
// emailbox_tx: outbound mailbox, queues 64-bit messages and sends each as LO then HI 32-bit writes
module emailbox_tx #(
    parameter int DW   = 32,
    parameter int RFAW = 5,
    parameter int FAW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mi_en,
    input  logic          mi_we,
    input  logic [19:0]   mi_addr,
    input  logic [DW-1:0] mi_din,
    output logic [DW-1:0] mi_dout,
    output logic          tx_access,
    output logic [31:0]   tx_dstaddr,
    output logic [DW-1:0] tx_data,
    input  logic          tx_wait,
    output logic          mbox_full,
    output logic          mbox_empty
);
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
    state_t          state_q;
    logic [2*DW-1:0] mem_q [2**FAW];
    logic [FAW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FAW:0]    cnt_q, cnt_d;
    logic [DW-1:0]   txlo_q, hold_hi_q, mi_dout_q, tx_data_q, rdata;
    logic [31:0]     dst_q, tx_dstaddr_q;
    logic [15:0]     txcount_q;
    logic            ovf_q, ovf_d, tx_access_q;
    logic [RFAW-1:0] idx;
    logic            wr, rd, push_req, push_ok, pop, accept, nonempty;
    logic [2*DW-1:0] head;
    logic            unused_addr;

    assign unused_addr = ^{mi_addr[19:RFAW+2], mi_addr[1:0]};

    always_comb begin
        idx      = mi_addr[RFAW+1:2];
        wr       = mi_en & mi_we;
        rd       = mi_en & ~mi_we;
        nonempty = |cnt_q;
        accept   = ~tx_wait;
        push_req = wr & (idx == RFAW'(1));
        // full is judged before any same-cycle pop, so a push at full is always dropped
        push_ok  = push_req & ~cnt_q[FAW];
        pop      = nonempty & ((state_q == IDLE) | ((state_q == SEND_HI) & accept));
        cnt_d    = cnt_q + (FAW+1)'(push_ok) - (FAW+1)'(pop);
        ovf_d    = (push_req & cnt_q[FAW]) | (ovf_q & ~(wr & (idx == RFAW'(3)) & mi_din[3]));
        head     = mem_q[rd_ptr_q];
        rdata    = idx == RFAW'(2) ? DW'(dst_q) :
                   idx == RFAW'(3) ? DW'({ovf_q, state_q != IDLE, cnt_q[FAW], nonempty}) :
                   idx == RFAW'(4) ? DW'(txcount_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (push_ok & ~reset)
            mem_q[wr_ptr_q] <= {mi_din, txlo_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            txlo_q       <= '0;
            hold_hi_q    <= '0;
            mi_dout_q    <= '0;
            tx_data_q    <= '0;
            dst_q        <= '0;
            tx_dstaddr_q <= '0;
            txcount_q    <= '0;
            ovf_q        <= 1'b0;
            tx_access_q  <= 1'b0;
        end else begin
            if (wr & (idx == RFAW'(0)))
                txlo_q <= mi_din;
            if (wr & (idx == RFAW'(2)))
                dst_q <= {mi_din[31:2], 2'b00};
            if (rd)
                mi_dout_q <= rdata;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if ((state_q == SEND_HI) & accept)
                txcount_q <= txcount_q + 16'd1;
            // DST is captured with the message so later TXDST writes only affect queued entries
            if (pop) begin
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                hold_hi_q    <= head[2*DW-1:DW];
                tx_access_q  <= 1'b1;
                tx_dstaddr_q <= dst_q;
                tx_data_q    <= head[DW-1:0];
                state_q      <= SEND_LO;
            end else if ((state_q == SEND_LO) & accept) begin
                tx_dstaddr_q <= tx_dstaddr_q + 32'd4;
                tx_data_q    <= hold_hi_q;
                state_q      <= SEND_HI;
            end else if ((state_q == SEND_HI) & accept) begin
                tx_access_q <= 1'b0;
                state_q     <= IDLE;
            end
        end
    end

    assign mi_dout    = mi_dout_q;
    assign tx_access  = tx_access_q;
    assign tx_dstaddr = tx_dstaddr_q;
    assign tx_data    = tx_data_q;
    assign mbox_full  = cnt_q[FAW];
    assign mbox_empty = ~nonempty & (state_q == IDLE);
endmodule

// File: tb/tb_emailbox_tx.sv
// tb_emailbox_tx: directed vector table plus hand sequences for stall, overflow, reset and DST capture
module tb_emailbox_tx;
    logic        clk, reset, mi_en, mi_we, tx_wait;
    logic [19:0] mi_addr;
    logic [31:0] mi_din, mi_dout, tx_dstaddr, tx_data;
    logic        tx_access, mbox_full, mbox_empty;
    int          tests, fails;
    logic [31:0] bd [64];
    logic [31:0] bv [64];
    int          bc [64];
    int          nb;
    logic [31:0] rv;

    typedef struct {
        logic        en, we;
        logic [4:0]  idx;
        logic [31:0] din;
        logic        wt, acc;
        logic [31:0] dst, data;
        logic        emp, chk;
        logic [31:0] dout;
    } vec_t;
    vec_t vt [19];

    emailbox_tx dut (
        .clk(clk), .reset(reset), .mi_en(mi_en), .mi_we(mi_we), .mi_addr(mi_addr),
        .mi_din(mi_din), .mi_dout(mi_dout), .tx_access(tx_access), .tx_dstaddr(tx_dstaddr),
        .tx_data(tx_data), .tx_wait(tx_wait), .mbox_full(mbox_full), .mbox_empty(mbox_empty)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input int en, we, input logic [4:0] idx, input logic [31:0] din,
                                input int wt, acc, input logic [31:0] dst, data,
                                input int emp, chk, input logic [31:0] dout);
        vec_t r;
        r.en = en[0]; r.we = we[0]; r.idx = idx; r.din = din; r.wt = wt[0]; r.acc = acc[0];
        r.dst = dst; r.data = data; r.emp = emp[0]; r.chk = chk[0]; r.dout = dout;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic en, input logic we, input logic [4:0] idx, input logic [31:0] d);
        mi_en = en; mi_we = we; mi_addr = {13'b0, idx, 2'b00}; mi_din = d;
        step();
        mi_en = 0; mi_we = 0;
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] d);
        cyc(1, 1, idx, d);
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [31:0] d);
        cyc(1, 0, idx, 0);
        d = mi_dout;
    endtask

    task automatic push(input logic [31:0] lo, input logic [31:0] hi);
        wr_reg(0, lo);
        wr_reg(1, hi);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    // each cycle with tx_access high while tx_wait is low is one accepted beat
    task automatic collect(input int cycles);
        nb = 0;
        for (int c = 0; c < cycles; c++) begin
            if (tx_access && nb < 64) begin
                bd[nb] = tx_dstaddr; bv[nb] = tx_data; bc[nb] = c; nb++;
            end
            step();
        end
    endtask

    task automatic check_beat(input string t, input int k, input logic [31:0] dst, input logic [31:0] data);
        check($sformatf("%s beat%0d dst", t, k), bd[k], dst);
        check($sformatf("%s beat%0d data", t, k), bv[k], data);
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1; mi_en = 0; mi_we = 0; mi_addr = 0; mi_din = 0; tx_wait = 0;
        step();
        check("reset tx_access", tx_access, 0);
        check("reset tx_dstaddr", tx_dstaddr, 0);
        check("reset tx_data", tx_data, 0);
        check("reset mi_dout", mi_dout, 0);
        check("reset full", mbox_full, 0);
        check("reset empty", mbox_empty, 1);
        reset = 0;

        vt[0]  = mk(1, 1, 2, 32'h8080_0000, 0, 0, 0, 0, 1, 0, 0);
        vt[1]  = mk(1, 1, 0, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 0);
        vt[2]  = mk(1, 1, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 1, 32'h8080_0000, 32'h1111_1111, 0, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 1, 32'h8080_0004, 32'h2222_2222, 0, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vt[6]  = mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 1);
        vt[7]  = mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 1, 32'h8080_0000);
        vt[8]  = mk(1, 1, 0, 32'h3333_3333, 0, 0, 0, 0, 1, 0, 0);
        vt[9]  = mk(1, 1, 1, 32'h4444_4444, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 10; i < 15; i++)
            vt[i] = mk(0, 0, 0, 0, 1, 1, 32'h8080_0000, 32'h3333_3333, 0, 0, 0);
        vt[15] = mk(0, 0, 0, 0, 0, 1, 32'h8080_0004, 32'h4444_4444, 0, 0, 0);
        vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vt[17] = mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 1, 0);
        vt[18] = mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 1, 2);

        for (int i = 0; i < 19; i++) begin
            mi_en = vt[i].en; mi_we = vt[i].we; mi_addr = {13'b0, vt[i].idx, 2'b00};
            mi_din = vt[i].din; tx_wait = vt[i].wt;
            step();
            check($sformatf("v%0d tx_access", i), tx_access, vt[i].acc);
            if (vt[i].acc) begin
                check($sformatf("v%0d tx_dstaddr", i), tx_dstaddr, vt[i].dst);
                check($sformatf("v%0d tx_data", i), tx_data, vt[i].data);
            end
            check($sformatf("v%0d empty", i), mbox_empty, vt[i].emp);
            check($sformatf("v%0d full", i), mbox_full, 0);
            if (vt[i].chk)
                check($sformatf("v%0d mi_dout", i), mi_dout, vt[i].dout);
        end
        mi_en = 0; mi_we = 0; tx_wait = 0;

        // overflow: one message held in the transmitter, sixteen queued, one dropped
        do_reset();
        wr_reg(2, 32'hA000_0000);
        tx_wait = 1;
        for (int i = 0; i < 17; i++)
            push(32'h1000 + i, 32'h2000 + i);
        check("ovf full", mbox_full, 1);
        check("ovf empty", mbox_empty, 0);
        push(32'h1011, 32'h2011);
        rd_reg(3, rv);
        check("ovf status", rv, 32'hF);
        tx_wait = 0;
        collect(45);
        check("ovf beat count", nb, 34);
        for (int k = 0; k < 17 && 2 * k + 1 < nb; k++) begin
            check_beat("ovf", 2 * k, 32'hA000_0000, 32'h1000 + k);
            check_beat("ovf", 2 * k + 1, 32'hA000_0004, 32'h2000 + k);
        end
        check("ovf drained empty", mbox_empty, 1);
        rd_reg(3, rv);
        check("ovf status sticky", rv, 32'h8);
        wr_reg(3, 32'h8);
        rd_reg(3, rv);
        check("ovf status cleared", rv, 32'h0);
        rd_reg(4, rv);
        check("ovf count", rv, 17);

        // back-to-back: three messages give six contiguous beats
        do_reset();
        fork
            for (int i = 0; i < 3; i++) push(32'h5000 + i, 32'h6000 + i);
            collect(14);
        join
        check("b2b beat count", nb, 6);
        if (nb == 6) begin
            check("b2b contiguous", bc[5] - bc[0], 5);
            for (int k = 0; k < 3; k++) begin
                check_beat("b2b", 2 * k, 32'h0, 32'h5000 + k);
                check_beat("b2b", 2 * k + 1, 32'h4, 32'h6000 + k);
            end
        end
        rd_reg(4, rv);
        check("b2b count", rv, 3);

        // reset while HI beat is stalled; reset also beats a same-cycle TXDST write
        wr_reg(2, 32'h7000_0000);
        push(32'hAAAA_0001, 32'hBBBB_0002);
        step();
        step();
        tx_wait = 1;
        step();
        step();
        check("stall hi access", tx_access, 1);
        check("stall hi dst", tx_dstaddr, 32'h7000_0004);
        check("stall hi data", tx_data, 32'hBBBB_0002);
        reset = 1; mi_en = 1; mi_we = 1; mi_addr = {13'b0, 5'd2, 2'b00}; mi_din = 32'h5555_5554;
        step();
        reset = 0; mi_en = 0; mi_we = 0; tx_wait = 0;
        check("rst tx_access", tx_access, 0);
        check("rst empty", mbox_empty, 1);
        check("rst full", mbox_full, 0);
        check("rst mi_dout", mi_dout, 0);
        rd_reg(4, rv);
        check("rst count", rv, 0);
        rd_reg(2, rv);
        check("rst dst", rv, 0);
        push(32'hCCCC_0003, 32'hDDDD_0004);
        collect(6);
        check("post-rst beat count", nb, 2);
        if (nb == 2) begin
            check_beat("post-rst", 0, 32'h0, 32'hCCCC_0003);
            check_beat("post-rst", 1, 32'h4, 32'hDDDD_0004);
        end
        rd_reg(4, rv);
        check("post-rst count", rv, 1);

        // DST change while a message is stalled applies only to the queued one
        wr_reg(2, 32'h8080_0000);
        tx_wait = 1;
        push(32'hA1A1_A1A1, 32'hA2A2_A2A2);
        push(32'hB1B1_B1B1, 32'hB2B2_B2B2);
        wr_reg(2, 32'h9000_0000);
        tx_wait = 0;
        collect(10);
        check("dst beat count", nb, 4);
        if (nb == 4) begin
            check_beat("dst", 0, 32'h8080_0000, 32'hA1A1_A1A1);
            check_beat("dst", 1, 32'h8080_0004, 32'hA2A2_A2A2);
            check_beat("dst", 2, 32'h9000_0000, 32'hB1B1_B1B1);
            check_beat("dst", 3, 32'h9000_0004, 32'hB2B2_B2B2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/emailbox_tx.md
Name: emailbox_tx

Overview:
- Outbound mailbox transmitter. Software writes 64-bit messages over the simple memory interface into a local FIFO.
- The block drains each FIFO entry as two 32-bit write transactions on the transmit port: low word to DST, then high word to DST+4.
- It is the sending end of a remote receive mailbox, which needs LO-then-HI consecutive writes.
- It sits between the host register bus and the elink transmit path.

Parameters:
- DW, 32, data width of bus and of each mailbox word
- RFAW, 5, register address field width; the register index is mi_addr[RFAW+1:2]
- FAW, 4, FIFO depth is 2^FAW 64-bit entries

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mi_en  in  1  register access strobe
- mi_we  in  1  1=write, 0=read
- mi_addr  in  20  byte address
- mi_din  in  DW  write data
- mi_dout  out  DW  registered read data
- tx_access  out  1  transaction valid
- tx_dstaddr  out  32  transaction destination address
- tx_data  out  DW  transaction data
- tx_wait  in  1  transmit path stall
- mbox_full  out  1  FIFO full
- mbox_empty  out  1  FIFO empty and no transaction in flight (use as interrupt)

Behaviour:
- Register index mi_addr[RFAW+1:2]:
  - 0 TXLO (W): shadow register for low word.
  - 1 TXHI (W): writing pushes {mi_din, TXLO shadow} into the FIFO.
  - 2 TXDST (R/W): 32-bit destination base address, word aligned; bits[1:0] are read as 0.
  - 3 TXSTATUS (R/W1C): [0] FIFO not empty, [1] full, [2] busy (state != IDLE), [3] overflow sticky; writing 1 to bit3 clears it.
  - 4 TXCOUNT (R): 16-bit count of completed messages, wraps 0xFFFF->0.
  - Other indices read 0; writes to them are ignored.
- Reads: mi_dout updates at the edge where mi_en & ~mi_we and holds otherwise. Read latency is one cycle.
- Push:
  - A TXHI write when the FIFO is full is dropped and sets overflow.
  - Full is evaluated before any same-cycle pop, so the push is dropped even if a pop occurs that cycle.
  - Overflow set and W1C clear in the same cycle: set wins.
- FIFO:
  - Occupancy counter 0..2^FAW. Read and write pointers are FAW bits and wrap naturally.
  - mbox_full = (count == 2^FAW).
  - A simultaneous push (not full) and pop leaves count unchanged.
- FSM states:
  - IDLE: if FIFO not empty, latch the head entry into an output holding register, pop the FIFO, go to SEND_LO.
  - SEND_LO: tx_access=1, tx_dstaddr=DST, tx_data=low word. At an edge with tx_wait=0 the beat is accepted; go to SEND_HI.
  - SEND_HI: tx_access=1, tx_dstaddr=DST+4, tx_data=high word. On acceptance, increment TXCOUNT; if the FIFO is not empty, latch and pop the next entry and go to SEND_LO, else go to IDLE.
- DST is sampled into the holding register at pop time. Writing TXDST mid-message does not affect the message in flight.
- While tx_wait=1, tx_access, tx_dstaddr and tx_data hold stable.
- Latency: a TXHI push at edge N puts tx_access high after edge N+1, with LO first. With tx_wait=0 throughout, back-to-back messages give tx_access continuously high, one beat per cycle.
- mbox_empty = (count == 0) & (state == IDLE).
- Reset: at a reset edge all state clears.
  - FIFO empties; state goes to IDLE.
  - tx_access=0, tx_dstaddr=0, tx_data=0, mi_dout=0.
  - TXDST=0, TXCOUNT=0, overflow=0, TXLO shadow=0.
  - mbox_full=0, mbox_empty=1.
  - A transaction in flight is abandoned; no completion is counted.
  - Reset overrides any same-cycle mi access.

Test Plan:
1. Write TXDST=0x8080_0000, TXLO=0x1111_1111, TXHI=0x2222_2222, tx_wait=0 -> two cycles after the TXHI cycle: beat (0x8080_0000, 0x1111_1111), then (0x8080_0004, 0x2222_2222); TXCOUNT=1; mbox_empty returns to 1.
2. Same message with tx_wait held 1 for 5 cycles during SEND_LO -> LO beat outputs stable for 5 cycles, accepted on the first edge with tx_wait=0, HI beat follows; no duplicate beats.
3. tx_wait=1, push 17 messages with FAW=4 -> one is popped into holding and 16 fill the FIFO, mbox_full=1. An 18th push is dropped and TXSTATUS=0xF. Release tx_wait -> exactly 17 messages sent in order; W1C bit3 -> TXSTATUS=0x0.
4. Push 3 messages back-to-back, tx_wait=0 -> 6 consecutive beats with tx_access continuously high; TXCOUNT=3.
5. Assert reset during a SEND_HI stall -> next cycle tx_access=0, TXCOUNT=0, mbox_empty=1; a new push after reset transmits normally.
6. Write TXDST=0x9000_0000 while a message is stalled in SEND_LO -> in-flight beats use the old DST; the next queued message uses 0x9000_0000/0x9000_0004.
